pixel_fetch_sequencer: RTL and testbench

Sequences per-pixel colour fetches from the Nios II pixel PIO handshake into a small colour FIFO read by the display scan-out logic. It walks the active frame in raster order and drives the pixel position and request to the processor. It then waits for the processor's acknowledge, captures the returned 24-bit colour, and buffers it ahead of the consumer. It sits between the Nios II system's pixel-position/request/colour PIOs and the video timing block.

---
 rtl/pixel_fetch_pkg.sv | 24 ++
 rtl/pixel_color_fifo.sv | 87 ++++++++
 rtl/pixel_fetch_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pixel_fetch_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fetch_pkg.sv
// Shared types, widths and helpers for the pixel fetch sequencer and its colour FIFO.
`timescale 1ns/1ps
package pixel_fetch_pkg;

   localparam int unsigned COLOR_W = 24;
   localparam int unsigned POS_W   = 32;
   localparam int unsigned COORD_W = 16;

   localparam logic [COLOR_W-1:0] BLACK = '0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SPACE,
      REQ,
      DRAIN
   } fetch_state_t;

   // Position word presented to the PIO: y in the upper half, x in the lower half.
   function automatic logic [POS_W-1:0] pack_position(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] y);
      return {y, x};
   endfunction

endpackage

// File: rtl/pixel_color_fifo.sv
// Synchronous show-ahead FIFO; head, level and flags are all registered.
`timescale 1ns/1ps
module pixel_color_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 24
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic [WIDTH-1:0]               wdata,
   input  logic                           pop,
   input  logic                           flush,
   output logic [WIDTH-1:0]               head,
   output logic [$clog2(DEPTH+1)-1:0]     level,
   output logic                           empty,
   output logic                           full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push_c;
   logic             do_pop_c;
   logic [LVL_W-1:0] level_nxt_c;
   logic [WIDTH-1:0] head_nxt_c;

   // Pops on empty are dropped; a push into a full FIFO is only taken alongside a pop.
   always_comb begin
      do_pop_c    = pop && !empty;
      do_push_c   = push && (!full || do_pop_c);
      level_nxt_c = level;
      head_nxt_c  = head;
      if (do_push_c && !do_pop_c) begin
         level_nxt_c = level + LVL_W'(1);
      end else if (!do_push_c && do_pop_c) begin
         level_nxt_c = level - LVL_W'(1);
      end
      if (do_pop_c) begin
         if (level > LVL_W'(1)) begin
            head_nxt_c = mem[rd_ptr + PTR_W'(1)];
         end else if (do_push_c) begin
            head_nxt_c = wdata;
         end
      end else if (do_push_c && empty) begin
         head_nxt_c = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_c) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Flush empties the FIFO but leaves the head register showing its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
         head   <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (do_push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         level <= level_nxt_c;
         empty <= (level_nxt_c == '0);
         full  <= (level_nxt_c == LVL_W'(DEPTH));
         head  <= head_nxt_c;
      end
   end

endmodule

// File: rtl/pixel_fetch_sequencer.sv
// Walks the active frame in raster order, fetching each pixel colour over a
// four-phase PIO handshake and buffering the results in a show-ahead FIFO.
`timescale 1ns/1ps
module pixel_fetch_sequencer
   import pixel_fetch_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic                              clk_clk,
   input  logic                              reset_reset_n,
   input  logic                              frame_start,
   output logic [POS_W-1:0]                  req_position,
   output logic                              req_valid,
   input  logic                              req_ack,
   input  logic [COLOR_W-1:0]                req_color,
   input  logic                              pix_pop,
   output logic                              pix_valid,
   output logic [COLOR_W-1:0]                pix_color,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              frame_done,
   output logic                              timeout_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

   fetch_state_t       state;
   fetch_state_t       state_nxt;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] x_nxt;
   logic [COORD_W-1:0] y;
   logic [COORD_W-1:0] y_nxt;
   logic               restart;
   logic               restart_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               req_valid_nxt;
   logic [POS_W-1:0]   req_position_nxt;
   logic               frame_done_nxt;
   logic               timeout_err_nxt;
   logic               ack_meta;
   logic               ack_sync;
   logic               push_c;
   logic               flush_c;
   logic [COLOR_W-1:0] push_data_c;
   logic               fifo_empty;
   logic               fifo_full;

   // Two-flop synchroniser for the processor's acknowledge.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         ack_meta <= 1'b0;
         ack_sync <= 1'b0;
      end else begin
         ack_meta <= req_ack;
         ack_sync <= ack_meta;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state        <= IDLE;
         x            <= '0;
         y            <= '0;
         restart      <= 1'b0;
         cnt          <= '0;
         req_valid    <= 1'b0;
         req_position <= '0;
         frame_done   <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state        <= state_nxt;
         x            <= x_nxt;
         y            <= y_nxt;
         restart      <= restart_nxt;
         cnt          <= cnt_nxt;
         req_valid    <= req_valid_nxt;
         req_position <= req_position_nxt;
         frame_done   <= frame_done_nxt;
         timeout_err  <= timeout_err_nxt;
      end
   end

   // A mid-frame restart abandons the handshake; DRAIN then waits out the ack without advancing.
   always_comb begin
      state_nxt        = state;
      x_nxt            = x;
      y_nxt            = y;
      restart_nxt      = restart;
      cnt_nxt          = '0;
      req_valid_nxt    = req_valid;
      req_position_nxt = req_position;
      frame_done_nxt   = 1'b0;
      timeout_err_nxt  = timeout_err;
      push_c           = 1'b0;
      push_data_c      = req_color;
      flush_c          = 1'b0;

      if (frame_start && (state != IDLE)) begin
         flush_c         = 1'b1;
         x_nxt           = '0;
         y_nxt           = '0;
         timeout_err_nxt = 1'b0;
         req_valid_nxt   = 1'b0;
         restart_nxt     = 1'b1;
         state_nxt       = DRAIN;
      end else begin
         case (state)
            IDLE: begin
               if (frame_start) begin
                  x_nxt           = '0;
                  y_nxt           = '0;
                  timeout_err_nxt = 1'b0;
                  restart_nxt     = 1'b0;
                  state_nxt       = WAIT_SPACE;
               end
            end
            WAIT_SPACE: begin
               if (!fifo_full) begin
                  req_valid_nxt    = 1'b1;
                  req_position_nxt = pack_position(x, y);
                  state_nxt        = REQ;
               end
            end
            REQ: begin
               if (ack_sync) begin
                  push_c        = 1'b1;
                  req_valid_nxt = 1'b0;
                  state_nxt     = DRAIN;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  push_c          = 1'b1;
                  push_data_c     = BLACK;
                  timeout_err_nxt = 1'b1;
                  req_valid_nxt   = 1'b0;
                  state_nxt       = DRAIN;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (!ack_sync) begin
                  state_nxt = WAIT_SPACE;
                  if (restart) begin
                     restart_nxt = 1'b0;
                  end else if ((x == X_LAST) && (y == Y_LAST)) begin
                     frame_done_nxt = 1'b1;
                     x_nxt          = '0;
                     y_nxt          = '0;
                     state_nxt      = IDLE;
                  end else if (x == X_LAST) begin
                     x_nxt = '0;
                     y_nxt = y + COORD_W'(1);
                  end else begin
                     x_nxt = x + COORD_W'(1);
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   pixel_color_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (COLOR_W)
   ) u_fifo (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .push  (push_c),
      .wdata (push_data_c),
      .pop   (pix_pop),
      .flush (flush_c),
      .head  (pix_color),
      .level (fifo_level),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign pix_valid = !fifo_empty;

endmodule

// File: tb/tb_pixel_fetch_sequencer.sv
// Randomised bench: raster-order position model plus a queue of expected colours.
`timescale 1ns/1ps
module tb_pixel_fetch_sequencer;

   localparam int unsigned H  = 4;
   localparam int unsigned V  = 2;
   localparam int unsigned D  = 4;
   localparam int unsigned TO = 20;

   logic                       clk_clk;
   logic                       reset_reset_n;
   logic                       frame_start;
   logic [31:0]                req_position;
   logic                       req_valid;
   logic                       req_ack;
   logic [23:0]                req_color;
   logic                       pix_pop;
   logic                       pix_valid;
   logic [23:0]                pix_color;
   logic [$clog2(D+1)-1:0]     fifo_level;
   logic                       frame_done;
   logic                       timeout_err;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   int          rv_rise_cnt = 0;
   logic        rv_prev = 1'b0;
   logic        pop_en;
   logic        pos_color;
   int          exp_x;
   int          exp_y;
   logic [23:0] exp_q [$];

   pixel_fetch_sequencer #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .FIFO_DEPTH (D),
      .TIMEOUT    (TO)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .frame_start   (frame_start),
      .req_position  (req_position),
      .req_valid     (req_valid),
      .req_ack       (req_ack),
      .req_color     (req_color),
      .pix_pop       (pix_pop),
      .pix_valid     (pix_valid),
      .pix_color     (pix_color),
      .fifo_level    (fifo_level),
      .frame_done    (frame_done),
      .timeout_err   (timeout_err)
   );

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One cycle: sample at the falling edge, then optionally pop and score the head.
   task automatic tick();
      @(negedge clk_clk);
      pix_pop = 1'b0;
      if (frame_done) done_cnt++;
      if (req_valid && !rv_prev) rv_rise_cnt++;
      rv_prev = req_valid;
      if (pop_en && pix_valid && ($urandom_range(1, 0) == 1)) begin
         if (exp_q.size() == 0) chk("pop_unexpected", 32'(1), 32'(0));
         else chk("pop_color", 32'(pix_color), 32'(exp_q.pop_front()));
         pix_pop = 1'b1;
      end
   endtask

   task automatic start_frame(input bit flush);
      if (flush) exp_q.delete();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      exp_x    = 0;
      exp_y    = 0;
      done_cnt = 0;
   endtask

   task automatic advance();
      exp_x++;
      if (exp_x == int'(H)) begin
         exp_x = 0;
         exp_y++;
      end
   endtask

   task automatic wait_req(input logic [23:0] c);
      int n = 0;
      while (!req_valid && n < 200) begin
         tick();
         n++;
      end
      if (!req_valid) chk("req_wait_expired", 32'(0), 32'(1));
      chk("req_pos", req_position, {16'(exp_y), 16'(exp_x)});
      exp_q.push_back(c);
   endtask

   function automatic logic [23:0] pick_color();
      if (pos_color) return {8'h0, 16'(exp_x)};
      return 24'($urandom);
   endfunction

   // Runs one request up to req_valid falling; hi counts samples with req_valid high.
   task automatic serve(input int lat, input bit ack, output int hi);
      logic [23:0] c;
      int n = 0;
      c = ack ? pick_color() : 24'h0;
      wait_req(c);
      hi = 1;
      if (ack) begin
         repeat (lat) tick();
         req_color = c;
         req_ack   = 1'b1;
      end
      while (req_valid && n < 200) begin
         tick();
         n++;
         if (req_valid) hi++;
      end
      if (req_valid) chk("req_fall_expired", 32'(0), 32'(1));
   endtask

   task automatic finish();
      repeat ($urandom_range(2, 0)) tick();
      req_ack   = 1'b0;
      req_color = 24'($urandom);
      advance();
   endtask

   task automatic serve_full(input int lat, input bit ack);
      int hi;
      serve(lat, ack, hi);
      finish();
   endtask

   task automatic end_frame(input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 80) begin
         tick();
         n++;
      end
      repeat (3) tick();
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(1));
      rv_rise_cnt = 0;
      repeat (12) tick();
      chk({tag, "_idle_no_req"}, 32'(rv_rise_cnt), 32'(0));
      pop_en = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || pix_valid) && n < 200) begin
         tick();
         n++;
      end
      repeat (2) tick();
      chk({tag, "_drain_queue"}, 32'(exp_q.size()), 32'(0));
      chk({tag, "_drain_level"}, 32'(fifo_level), 32'(0));
   endtask

   initial begin
      int hi;
      logic [23:0] c;
      reset_reset_n = 1'b0;
      frame_start   = 1'b0;
      req_ack       = 1'b0;
      req_color     = '0;
      pix_pop       = 1'b0;
      pop_en        = 1'b0;
      pos_color     = 1'b1;
      exp_x         = 0;
      exp_y         = 0;
      repeat (3) tick();
      chk("rst_req_valid", 32'(req_valid), 32'(0));
      chk("rst_req_position", req_position, 32'(0));
      chk("rst_pix_valid", 32'(pix_valid), 32'(0));
      chk("rst_pix_color", 32'(pix_color), 32'(0));
      chk("rst_fifo_level", 32'(fifo_level), 32'(0));
      chk("rst_frame_done", 32'(frame_done), 32'(0));
      chk("rst_timeout_err", 32'(timeout_err), 32'(0));
      reset_reset_n = 1'b1;
      repeat (3) tick();

      // Reset while a request is outstanding.
      start_frame(1'b0);
      wait_req(24'h0);
      reset_reset_n = 1'b0;
      #1;
      chk("midreq_rst_req_valid", 32'(req_valid), 32'(0));
      chk("midreq_rst_req_position", req_position, 32'(0));
      chk("midreq_rst_level", 32'(fifo_level), 32'(0));
      exp_q.delete();
      tick();
      reset_reset_n = 1'b1;
      rv_rise_cnt = 0;
      repeat (12) tick();
      chk("midreq_rst_stays_idle", 32'(rv_rise_cnt), 32'(0));

      // Basic frame with a fixed 5-cycle responder and colour derived from position.
      pop_en    = 1'b1;
      pos_color = 1'b1;
      start_frame(1'b0);
      while (exp_y < int'(V)) serve_full(5, 1'b1);
      end_frame("basic");

      // Backpressure: FIFO fills, then one pop lets exactly one request through.
      pop_en = 1'b0;
      start_frame(1'b0);
      repeat (D) serve_full(int'($urandom_range(3, 0)), 1'b1);
      rv_rise_cnt = 0;
      repeat (20) tick();
      chk("bp_level_full", 32'(fifo_level), 32'(D));
      chk("bp_no_new_req", 32'(rv_rise_cnt), 32'(0));
      chk("bp_req_valid_low", 32'(req_valid), 32'(0));
      chk("bp_head", 32'(pix_color), 32'(exp_q[0]));
      pix_pop = 1'b1;
      void'(exp_q.pop_front());
      rv_rise_cnt = 0;
      tick();
      serve_full(1, 1'b1);
      repeat (20) tick();
      chk("bp_one_req", 32'(rv_rise_cnt), 32'(1));
      chk("bp_level_refull", 32'(fifo_level), 32'(D));
      pop_en = 1'b1;
      while (exp_y < int'(V)) serve_full(int'($urandom_range(4, 0)), 1'b1);
      end_frame("bp");

      // Timeout: no acknowledge at all.
      pop_en = 1'b0;
      start_frame(1'b0);
      serve(0, 1'b0, hi);
      chk("to_req_high_cycles", 32'(hi), 32'(TO + 1));
      chk("to_err_set", 32'(timeout_err), 32'(1));
      chk("to_level", 32'(fifo_level), 32'(1));
      chk("to_black", 32'(pix_color), 32'(0));
      finish();
      start_frame(1'b1);
      chk("to_err_cleared", 32'(timeout_err), 32'(0));
      chk("to_flush_level", 32'(fifo_level), 32'(0));

      // Restart while the acknowledge is already high and the colour is due.
      pos_color = 1'b0;
      serve_full(int'($urandom_range(3, 0)), 1'b1);
      serve_full(int'($urandom_range(3, 0)), 1'b1);
      chk("rs_level_before", 32'(fifo_level), 32'(2));
      c = pick_color();
      wait_req(c);
      req_color = c;
      req_ack   = 1'b1;
      tick();
      tick();
      start_frame(1'b1);
      chk("rs_flush_level", 32'(fifo_level), 32'(0));
      chk("rs_flush_valid", 32'(pix_valid), 32'(0));
      rv_rise_cnt = 0;
      repeat (10) tick();
      chk("rs_no_req_while_ack", 32'(rv_rise_cnt), 32'(0));
      chk("rs_req_valid_low", 32'(req_valid), 32'(0));
      req_ack = 1'b0;

      // Push and pop in the same cycle at level 2.
      serve_full(int'($urandom_range(3, 0)), 1'b1);
      serve_full(int'($urandom_range(3, 0)), 1'b1);
      chk("pp_level_before", 32'(fifo_level), 32'(2));
      c = pick_color();
      wait_req(c);
      req_color = c;
      req_ack   = 1'b1;
      tick();
      tick();
      chk("pp_head_before", 32'(pix_color), 32'(exp_q[0]));
      pix_pop = 1'b1;
      void'(exp_q.pop_front());
      tick();
      chk("pp_level_after", 32'(fifo_level), 32'(2));
      chk("pp_head_after", 32'(pix_color), 32'(exp_q[0]));
      while (req_valid) tick();
      finish();
      pop_en = 1'b1;
      while (exp_y < int'(V)) serve_full(int'($urandom_range(4, 0)), 1'b1);
      end_frame("rs");

      // Randomised frames: random latency, random colours, occasional missing ack.
      for (int f = 0; f < 4; f++) begin
         start_frame(1'b0);
         chk("rand_err_clear", 32'(timeout_err), 32'(0));
         while (exp_y < int'(V))
            serve_full(int'($urandom_range(6, 0)), ($urandom_range(7, 0) != 0));
         end_frame("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
